// File: rtl/cdb_rr_arbiter_if.sv
// cdb_rr_arbiter_if
//   Bundles the FU-side result handshake and the CDB broadcast channels of
//   cdb_rr_arbiter.
//   fu_valid  [NUM_FU]          FU i presents a result
//   fu_tag    [NUM_FU*TAG_W]    ROB tag per FU, FU i at [i*TAG_W +: TAG_W]
//   fu_data   [NUM_FU*DATA_W]   result value per FU
//   fu_ready  [NUM_FU]          FU i buffer can accept the result
//   cdb_valid [NUM_CDB]         channel k broadcasts this cycle
//   cdb_tag   [NUM_CDB*TAG_W]   broadcast tag per channel
//   cdb_data  [NUM_CDB*DATA_W]  broadcast value per channel
//   cdb_fu_id [NUM_CDB*ID_W]    source FU index per channel
//   modport master: FU / broadcast-consumer side
//   modport slave : the arbiter
interface cdb_rr_arbiter_if #(
    parameter int NUM_FU  = 4,
    parameter int NUM_CDB = 2,
    parameter int TAG_W   = 5,
    parameter int DATA_W  = 32,
    parameter int ID_W    = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
);
    logic [NUM_FU-1:0]         fu_valid;
    logic [NUM_FU*TAG_W-1:0]   fu_tag;
    logic [NUM_FU*DATA_W-1:0]  fu_data;
    logic [NUM_FU-1:0]         fu_ready;
    logic [NUM_CDB-1:0]        cdb_valid;
    logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
    logic [NUM_CDB*DATA_W-1:0] cdb_data;
    logic [NUM_CDB*ID_W-1:0]   cdb_fu_id;

    modport master (
        output fu_valid, fu_tag, fu_data,
        input  fu_ready, cdb_valid, cdb_tag, cdb_data, cdb_fu_id
    );

    modport slave (
        input  fu_valid, fu_tag, fu_data,
        output fu_ready, cdb_valid, cdb_tag, cdb_data, cdb_fu_id
    );
endinterface

// File: rtl/cdb_rr_arbiter.sv
// cdb_rr_arbiter
//   Multi-channel common data bus arbiter. Each FU result is queued in a
//   per-FU FIFO of BUF_DEPTH entries; every cycle up to NUM_CDB non-empty
//   FIFO heads are granted in round-robin order starting at rr_ptr and are
//   broadcast from registered CDB channels on the following cycle.
//   Ports:
//     clock  system clock
//     reset  asynchronous, active-high reset
//     flush  synchronous squash of all buffered and in-flight results
//     bus    cdb_rr_arbiter_if.slave (FU handshake + CDB channels)
//   Optional feature macro CDB_BYPASS_EN: an incoming result for an empty
//   FIFO joins the same cycle's arbitration and, if granted, is broadcast
//   after one edge without being written into the FIFO.
module cdb_rr_arbiter #(
    parameter int NUM_FU    = 4,
    parameter int NUM_CDB   = 2,
    parameter int TAG_W     = 5,
    parameter int DATA_W    = 32,
    parameter int BUF_DEPTH = 2
) (
    input logic              clock,
    input logic              reset,
    input logic              flush,
    cdb_rr_arbiter_if.slave  bus
);
    localparam int ID_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int CH_W  = (NUM_CDB > 1) ? $clog2(NUM_CDB) : 1;
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    logic [TAG_W-1:0]  tag_mem  [NUM_FU][BUF_DEPTH];
    logic [DATA_W-1:0] data_mem [NUM_FU][BUF_DEPTH];
    logic [PTR_W-1:0]  rd_ptr   [NUM_FU];
    logic [PTR_W-1:0]  wr_ptr   [NUM_FU];
    logic [CNT_W-1:0]  count    [NUM_FU];
    logic [ID_W-1:0]   rr_ptr;

    logic [NUM_FU-1:0] ready;
    logic [NUM_FU-1:0] push;
    logic [NUM_FU-1:0] head_vld;
    logic [NUM_FU-1:0] grant;
    logic [NUM_FU-1:0] pop;
    logic [NUM_FU-1:0] write;
    logic [TAG_W-1:0]  head_tag  [NUM_FU];
    logic [DATA_W-1:0] head_data [NUM_FU];

    logic [NUM_CDB-1:0] ch_vld;
    logic [TAG_W-1:0]   ch_tag  [NUM_CDB];
    logic [DATA_W-1:0]  ch_data [NUM_CDB];
    logic [ID_W-1:0]    ch_id   [NUM_CDB];
    logic [ID_W-1:0]    rr_nxt;

    logic [NUM_CDB-1:0]        cdb_valid_q;
    logic [NUM_CDB*TAG_W-1:0]  cdb_tag_q;
    logic [NUM_CDB*DATA_W-1:0] cdb_data_q;
    logic [NUM_CDB*ID_W-1:0]   cdb_fu_id_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (32'(p) == BUF_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    // Readiness looks only at the current occupancy; a same-cycle pop does
    // not make room for a same-cycle push.
    always_comb begin
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            ready[i] = !reset && (32'(count[i]) < BUF_DEPTH);
            push[i]  = bus.fu_valid[i] && ready[i];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            head_vld[i]  = (count[i] != '0);
            head_tag[i]  = tag_mem[i][rd_ptr[i]];
            head_data[i] = data_mem[i][rd_ptr[i]];
`ifdef CDB_BYPASS_EN
            if (count[i] == '0 && push[i]) begin
                head_vld[i]  = 1'b1;
                head_tag[i]  = bus.fu_tag[i*TAG_W +: TAG_W];
                head_data[i] = bus.fu_data[i*DATA_W +: DATA_W];
            end
`endif
        end
    end

    // Round-robin scan from rr_ptr; the n-th non-empty head goes to channel n.
    always_comb begin
        int unsigned n;
        int unsigned idx;
        int unsigned last;
        logic        any;
        grant  = '0;
        ch_vld = '0;
        for (int unsigned c = 0; c < NUM_CDB; c++) begin
            ch_tag[c]  = '0;
            ch_data[c] = '0;
            ch_id[c]   = '0;
        end
        n    = 0;
        last = 0;
        any  = 1'b0;
        for (int unsigned off = 0; off < NUM_FU; off++) begin
            idx = 32'(rr_ptr) + off;
            if (idx >= NUM_FU) idx = idx - NUM_FU;
            if (head_vld[ID_W'(idx)] && n < NUM_CDB) begin
                grant[ID_W'(idx)]   = 1'b1;
                ch_vld[CH_W'(n)]    = 1'b1;
                ch_tag[CH_W'(n)]    = head_tag[ID_W'(idx)];
                ch_data[CH_W'(n)]   = head_data[ID_W'(idx)];
                ch_id[CH_W'(n)]     = ID_W'(idx);
                n    = n + 1;
                last = idx;
                any  = 1'b1;
            end
        end
        rr_nxt = rr_ptr;
        if (any) rr_nxt = (last + 1 == NUM_FU) ? '0 : ID_W'(last + 1);
    end

    // A grant on an empty FIFO can only be a bypassed input: it is consumed
    // directly, so it is neither popped nor written.
    always_comb begin
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            pop[i]   = grant[i] && (count[i] != '0);
            write[i] = push[i] && !(grant[i] && count[i] == '0);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset || flush) begin
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr_ptr      <= '0;
            cdb_valid_q <= '0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_fu_id_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                if (pop[i])   rd_ptr[i] <= ptr_inc(rd_ptr[i]);
                if (write[i]) wr_ptr[i] <= ptr_inc(wr_ptr[i]);
                case ({write[i], pop[i]})
                    2'b10:   count[i] <= count[i] + 1'b1;
                    2'b01:   count[i] <= count[i] - 1'b1;
                    default: count[i] <= count[i];
                endcase
            end
            rr_ptr      <= rr_nxt;
            cdb_valid_q <= ch_vld;
            for (int unsigned c = 0; c < NUM_CDB; c++) begin
                cdb_tag_q[c*TAG_W +: TAG_W]    <= ch_tag[c];
                cdb_data_q[c*DATA_W +: DATA_W] <= ch_data[c];
                cdb_fu_id_q[c*ID_W +: ID_W]    <= ch_id[c];
            end
        end
    end

    // Payload storage carries no reset; occupancy is tracked by count.
    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (write[i] && !flush) begin
                tag_mem[i][wr_ptr[i]]  <= bus.fu_tag[i*TAG_W +: TAG_W];
                data_mem[i][wr_ptr[i]] <= bus.fu_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign bus.fu_ready  = ready;
    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_tag   = cdb_tag_q;
    assign bus.cdb_data  = cdb_data_q;
    assign bus.cdb_fu_id = cdb_fu_id_q;
endmodule

// File: tb/tb_cdb_rr_arbiter.sv
// tb_cdb_rr_arbiter
//   Two arbiters (NUM_CDB=2 as "A", NUM_CDB=1 as "B"; NUM_FU=4, BUF_DEPTH=2)
//   share clock/reset/flush. A queue-level model predicts every broadcast
//   and fu_ready value; directed sequences add literal expectations.
module tb_cdb_rr_arbiter;
    localparam int NF  = 4;
    localparam int TW  = 5;
    localparam int DW  = 32;
    localparam int DEP = 2;
    localparam int NC [2] = '{2, 1};

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    always #5 clock = ~clock;

    cdb_rr_arbiter_if #(.NUM_FU(NF), .NUM_CDB(2), .TAG_W(TW), .DATA_W(DW)) ifa ();
    cdb_rr_arbiter_if #(.NUM_FU(NF), .NUM_CDB(1), .TAG_W(TW), .DATA_W(DW)) ifb ();

    cdb_rr_arbiter #(.NUM_FU(NF), .NUM_CDB(2), .TAG_W(TW), .DATA_W(DW), .BUF_DEPTH(DEP))
        dut_a (.clock(clock), .reset(reset), .flush(flush), .bus(ifa.slave));
    cdb_rr_arbiter #(.NUM_FU(NF), .NUM_CDB(1), .TAG_W(TW), .DATA_W(DW), .BUF_DEPTH(DEP))
        dut_b (.clock(clock), .reset(reset), .flush(flush), .bus(ifb.slave));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [TW-1:0] mq_tag  [2][NF][$];
    logic [DW-1:0] mq_data [2][NF][$];
    int            m_rr    [2];
    logic [1:0]    e_valid [2];
    logic [TW-1:0] e_tag   [2][2];
    logic [DW-1:0] e_data  [2][2];
    logic [1:0]    e_id    [2][2];

    task automatic model_clear(input int k);
        for (int i = 0; i < NF; i++) begin
            mq_tag[k][i].delete();
            mq_data[k][i].delete();
        end
        m_rr[k]    = 0;
        e_valid[k] = '0;
        for (int c = 0; c < 2; c++) begin
            e_tag[k][c] = '0; e_data[k][c] = '0; e_id[k][c] = '0;
        end
    endtask

    task automatic model_step(input int k, input logic [NF-1:0] v,
                              input logic [NF*TW-1:0] t, input logic [NF*DW-1:0] d);
        bit rdy [NF];
        int n, last, i;
        for (int j = 0; j < NF; j++) rdy[j] = mq_tag[k][j].size() < DEP;
        e_valid[k] = '0;
        for (int c = 0; c < 2; c++) begin
            e_tag[k][c] = '0; e_data[k][c] = '0; e_id[k][c] = '0;
        end
        n = 0;
        last = -1;
        for (int off = 0; off < NF; off++) begin
            i = (m_rr[k] + off) % NF;
            if (n < NC[k] && mq_tag[k][i].size() > 0) begin
                e_valid[k][n] = 1'b1;
                e_tag[k][n]   = mq_tag[k][i].pop_front();
                e_data[k][n]  = mq_data[k][i].pop_front();
                e_id[k][n]    = 2'(i);
                n++;
                last = i;
            end
        end
        if (last >= 0) m_rr[k] = (last + 1) % NF;
        for (int j = 0; j < NF; j++) begin
            if (v[j] && rdy[j]) begin
                mq_tag[k][j].push_back(t[j*TW +: TW]);
                mq_data[k][j].push_back(d[j*DW +: DW]);
            end
        end
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset || flush) begin
            model_clear(0);
            model_clear(1);
        end else begin
            model_step(0, ifa.fu_valid, ifa.fu_tag, ifa.fu_data);
            model_step(1, ifb.fu_valid, ifb.fu_tag, ifb.fu_data);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        logic [1:0]      dv  [2];
        logic [2*TW-1:0] dt  [2];
        logic [2*DW-1:0] dd  [2];
        logic [3:0]      di  [2];
        logic [NF-1:0]   dr  [2];
        logic [NF-1:0]   er;
        dv[0] = ifa.cdb_valid;          dv[1] = {1'b0, ifb.cdb_valid};
        dt[0] = ifa.cdb_tag;            dt[1] = {{TW{1'b0}}, ifb.cdb_tag};
        dd[0] = ifa.cdb_data;           dd[1] = {{DW{1'b0}}, ifb.cdb_data};
        di[0] = ifa.cdb_fu_id;          di[1] = {2'b00, ifb.cdb_fu_id};
        dr[0] = ifa.fu_ready;           dr[1] = ifb.fu_ready;
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < NF; j++) er[j] = !reset && (mq_tag[k][j].size() < DEP);
            chk($sformatf("model_ready[%0d]", k), 64'(dr[k]), 64'(er));
            chk($sformatf("model_valid[%0d]", k), 64'(dv[k]), 64'(e_valid[k]));
            for (int c = 0; c < NC[k]; c++) begin
                chk($sformatf("model_tag[%0d][%0d]", k, c), 64'(dt[k][c*TW +: TW]), 64'(e_tag[k][c]));
                chk($sformatf("model_data[%0d][%0d]", k, c), 64'(dd[k][c*DW +: DW]), 64'(e_data[k][c]));
                chk($sformatf("model_id[%0d][%0d]", k, c), 64'(di[k][c*2 +: 2]), 64'(e_id[k][c]));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        ifa.fu_valid = '0; ifa.fu_tag = '0; ifa.fu_data = '0;
        ifb.fu_valid = '0; ifb.fu_tag = '0; ifb.fu_data = '0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [TW-1:0] got [$];
        logic [TW-1:0] seq [3];
        int            idx;
        bit            acc;
        bit            saw_block;
        idle_inputs();
        tick();
        tick();
        chk("reset_valid", 64'(ifa.cdb_valid), 64'(0));
        chk("reset_ready", 64'(ifa.fu_ready), 64'(0));
        reset = 1'b0;
        tick();
        chk("post_reset_ready", 64'(ifa.fu_ready), 64'hf);

        // 1: single result from FU2
        ifa.fu_valid = 4'b0100;
        ifa.fu_tag[2*TW +: TW]  = 5'd5;
        ifa.fu_data[2*DW +: DW] = 32'hAAAA;
        tick();
        idle_inputs();
        chk("t1_not_yet", 64'(ifa.cdb_valid), 64'(0));
        tick();
        chk("t1_valid", 64'(ifa.cdb_valid), 64'b01);
        chk("t1_tag",   64'(ifa.cdb_tag[TW-1:0]), 64'd5);
        chk("t1_data",  64'(ifa.cdb_data[DW-1:0]), 64'hAAAA);
        chk("t1_id",    64'(ifa.cdb_fu_id[1:0]), 64'd2);
        tick();
        chk("t1_drained", 64'(ifa.cdb_valid), 64'(0));
        do_flush();

        // 2: contention, rr_ptr = 0
        ifa.fu_valid = 4'b1111;
        for (int i = 0; i < NF; i++) begin
            ifa.fu_tag[i*TW +: TW]  = 5'(i + 1);
            ifa.fu_data[i*DW +: DW] = 32'h100 + 32'(i);
        end
        tick();
        idle_inputs();
        tick();
        chk("t2_c1_valid", 64'(ifa.cdb_valid), 64'b11);
        chk("t2_c1_tags",  64'(ifa.cdb_tag), 64'({5'd2, 5'd1}));
        chk("t2_c1_ids",   64'(ifa.cdb_fu_id), 64'({2'd1, 2'd0}));
        tick();
        chk("t2_c2_valid", 64'(ifa.cdb_valid), 64'b11);
        chk("t2_c2_tags",  64'(ifa.cdb_tag), 64'({5'd4, 5'd3}));
        chk("t2_c2_ids",   64'(ifa.cdb_fu_id), 64'({2'd3, 2'd2}));
        tick();
        chk("t2_idle", 64'(ifa.cdb_valid), 64'(0));
        // rr_ptr back at 0: FU0 must outrank FU3
        ifa.fu_valid = 4'b1001;
        ifa.fu_tag   = {5'd9, 5'd0, 5'd0, 5'd6};
        tick();
        idle_inputs();
        tick();
        chk("t2_rr0_ids", 64'(ifa.cdb_fu_id), 64'({2'd3, 2'd0}));

        // 3: fairness on B (single channel)
        ifb.fu_valid = 4'b0011;
        ifb.fu_tag   = {5'd0, 5'd0, 5'd17, 5'd16};
        tick();
        for (int n = 0; n < 8; n++) begin
            tick();
            chk($sformatf("t3_valid_%0d", n), 64'(ifb.cdb_valid), 64'd1);
            chk($sformatf("t3_id_%0d", n), 64'(ifb.cdb_fu_id), 64'(n % 2));
        end
        idle_inputs();
        repeat (5) tick();
        do_flush();

        // 4: backpressure on B, FU3 sends 7,8,9 while FU0 saturates
        seq = '{5'd7, 5'd8, 5'd9};
        idx = 0;
        saw_block = 1'b0;
        ifb.fu_valid = 4'b1001;
        ifb.fu_tag[0 +: TW]    = 5'd20;
        ifb.fu_tag[3*TW +: TW] = seq[0];
        for (int cyc = 0; cyc < 20; cyc++) begin
            acc = ifb.fu_valid[3] && ifb.fu_ready[3];
            if (idx == 2 && !ifb.fu_ready[3]) saw_block = 1'b1;
            tick();
            if (ifb.cdb_valid[0] && ifb.cdb_fu_id == 2'd3) got.push_back(ifb.cdb_tag);
            if (acc) begin
                idx++;
                if (idx < 3) ifb.fu_tag[3*TW +: TW] = seq[idx];
                else         ifb.fu_valid[3] = 1'b0;
            end
        end
        chk("t4_tag9_blocked", 64'(saw_block), 64'd1);
        chk("t4_all_accepted", 64'(idx), 64'd3);
        chk("t4_count", 64'(got.size()), 64'd3);
        for (int n = 0; n < 3 && n < got.size(); n++)
            chk($sformatf("t4_order_%0d", n), 64'(got[n]), 64'(seq[n]));
        idle_inputs();
        repeat (4) tick();

        // 5: flush with three FIFOs occupied on A
        ifa.fu_valid = 4'b0111;
        ifa.fu_tag   = {5'd0, 5'd12, 5'd11, 5'd10};
        tick();
        tick();
        chk("t5_pre_valid", 64'(ifa.cdb_valid), 64'b11);
        flush = 1'b1;
        ifa.fu_valid = 4'b0010;
        ifa.fu_tag   = {5'd0, 5'd0, 5'd31, 5'd0};
        tick();
        flush = 1'b0;
        idle_inputs();
        chk("t5_valid", 64'(ifa.cdb_valid), 64'(0));
        chk("t5_ready", 64'(ifa.fu_ready), 64'hf);
        repeat (3) tick();
        chk("t5_no_stale", 64'(ifa.cdb_valid), 64'(0));

        // 6: asynchronous reset mid-operation
        ifa.fu_valid = 4'b1111;
        ifa.fu_tag   = {5'd14, 5'd13, 5'd12, 5'd11};
        ifa.fu_data  = {32'h4, 32'h3, 32'h2, 32'h1};
        tick();
        idle_inputs();
        tick();
        chk("t6_pre_valid", 64'(ifa.cdb_valid), 64'b11);
        #1 reset = 1'b1;
        #1;
        chk("t6_valid", 64'(ifa.cdb_valid), 64'(0));
        chk("t6_tag",   64'(ifa.cdb_tag), 64'(0));
        chk("t6_data",  64'(ifa.cdb_data), 64'(0));
        chk("t6_ready", 64'(ifa.fu_ready), 64'(0));
        tick();
        reset = 1'b0;
        tick();
        ifa.fu_valid = 4'b1010;
        ifa.fu_tag   = {5'd23, 5'd0, 5'd21, 5'd0};
        tick();
        idle_inputs();
        tick();
        chk("t6_fresh_valid", 64'(ifa.cdb_valid), 64'b11);
        chk("t6_fresh_tags",  64'(ifa.cdb_tag), 64'({5'd23, 5'd21}));
        chk("t6_fresh_ids",   64'(ifa.cdb_fu_id), 64'({2'd3, 2'd1}));
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
